// File: rtl/fetch_unit.sv
// Instruction-fetch / PC-sequencing stage.
// Fetches one word per instruction over a req/ready handshake, holds it in
// instr while the controller executes it, then picks the next PC from the
// controller's jump/pcsrc decision when the instruction retires.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | just out of reset; moves to FETCH on the next edge
// FETCH | imem_req high, imem_addr = pc, waiting for imem_ready
// EXEC  | instr valid; held while stall, retires (pc/instret update) on !stall

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        latch_instr;
  logic        retire;
  logic [31:0] signimm;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  // State register; reset aborts any fetch in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    latch_instr = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          latch_instr = 1'b1;
          state_next  = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Next-PC selection; jump takes priority over a taken branch.
  // All candidates are word aligned, so pc[1:0] stays zero.
  always_comb begin
    signimm       = {{16{instr[15]}}, instr[15:0]};
    branch_target = pc_plus4 + {signimm[29:0], 2'b00};
    jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Architectural state: latched word, PC and retired count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC_ALIGNED;
      instr   <= 32'h0;
      instret <= 32'h0;
    end else begin
      if (latch_instr) begin
        instr <= imem_rdata;
      end
      if (retire) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage that sits directly upstream of the main controller.
- Holds the PC and issues requests to a variable-latency instruction memory through a req/ready handshake.
- Latches the returned word and presents opcode/funct to the controller.
- Uses the controller's pcsrc/jump outputs to select the next PC: sequential, branch or jump.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] are forced to 0 internally.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch byte address (= pc)
imem_ready  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
pcsrc  input  1  taken branch from controller (branch && zero)
jump  input  1  jump from controller
stall  input  1  datapath not ready to retire current instruction
instr  output  32  latched instruction
opcode  output  6  instr[31:26]
funct  output  6  instr[5:0]
instr_valid  output  1  instr is valid and executing this cycle
pc  output  32  address of current instruction
pc_plus4  output  32  pc + 4
instret  output  32  retired-instruction counter

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, pc=RESET_PC & ~3, instr=0, instret=0, imem_req=0, instr_valid=0. Reset asserted at any time, including mid-fetch or mid-EXEC, aborts the operation immediately; the pending memory response is discarded.
- States:
  - IDLE: entered only from reset. Unconditionally goes to FETCH on the first clk edge after reset deasserts.
  - FETCH:
    - imem_req=1, imem_addr=pc, instr_valid=0.
    - Address is held stable until imem_ready.
    - On edge with imem_ready=1: instr<=imem_rdata, go EXEC.
    - Otherwise remain in FETCH, with no limit on wait cycles.
  - EXEC:
    - imem_req=0, instr_valid=1.
    - The controller and datapath evaluate instr combinationally in this cycle.
    - stall=1: remain in EXEC; pc, instr and instret are unchanged.
    - stall=0: on the edge, pc<=next_pc, instret<=instret+1, go FETCH.
- imem_ready is ignored outside FETCH.
- Next-PC selection, sampled only on the retiring EXEC edge:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over pcsrc when both are high.
  - else pcsrc=1: pc_plus4 + (signimm << 2), where signimm = sign-extended instr[15:0].
  - else: pc_plus4.
- Arithmetic:
  - All additions are 32-bit modulo; PC wraps 32'hFFFFFFFC -> 0.
  - instret wraps 32'hFFFFFFFF -> 0.
  - Negative branch offsets must work, e.g. offset 16'hFFFF gives target = pc.
  - pc[1:0] is always 0.
- Latency:
  - Minimum 2 cycles per instruction: FETCH with ready in the same cycle, then EXEC.
  - CPI = 2 + memory wait cycles + stall cycles.
- opcode, funct, pc_plus4: combinational from instr/pc; valid only while instr_valid=1.

Test Plan:
- Reset with RESET_PC=32'h00400000, imem_ready=1 tied: first req at 0x00400000; sequential fetches at 0x00400004, then 0x00400008, one instruction every 2 cycles; instret counts 1, 2, 3.
- imem_ready low for 3 cycles in FETCH: imem_addr stays stable, instr_valid=0 throughout, EXEC begins the cycle after ready; instr equals the rdata sampled at ready.
- beq with offset 16'hFFFE at pc 0x100, pcsrc=1: next fetch address 0x0FC. Same instruction with pcsrc=0: next fetch 0x104.
- jump with instr[25:0]=26'h0000040 at pc 0x10000000, and also with pcsrc=1 simultaneously: next fetch 0x10000100 in both cases (jump wins).
- stall=1 for 4 EXEC cycles: pc, instr and instret are frozen and instr_valid stays 1; retire occurs on the first edge with stall=0.
- Assert reset mid-FETCH with imem_ready pulsed in the same cycle: outputs return to reset values immediately and the rdata is not latched. Separately, pc=32'hFFFFFFFC sequential retire: next fetch at 0.
